// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RV32 control unit: opcodes, FSM state
// encoding, datapath select codes and the opcode-class bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_e;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_r;
    logic is_i;
    logic is_beq;
    logic is_jal;
    logic is_illegal;
  } op_class_t;

endpackage

// File: rtl/op_class_decoder.sv
// Classifies the instruction-register opcode into one-hot instruction classes
// and selects the immediate format. Purely combinational.
module op_class_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_JAL = 1'b1
) (
  input  logic [6:0] op,
  output op_class_t  op_class,
  output logic [1:0] imm_src
);

  // Opcode -> class flags and immediate format.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    op_class = '0;
    imm_src  = IMM_I;
    unique case (op)
      OP_LOAD:  op_class.is_load  = 1'b1;
      OP_STORE: begin
        op_class.is_store = 1'b1;
        imm_src           = IMM_S;
      end
      OP_R:     op_class.is_r     = 1'b1;
      OP_I:     op_class.is_i     = 1'b1;
      OP_BEQ: begin
        op_class.is_beq = 1'b1;
        imm_src         = IMM_B;
      end
      OP_JAL: begin
        // With jal support stripped the opcode is simply unsupported.
        if (EN_JAL) op_class.is_jal     = 1'b1;
        else        op_class.is_illegal = 1'b1;
        imm_src = IMM_J;
      end
      default:  op_class.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with a variable-latency memory handshake, a memory
// timeout and sticky illegal/bus-error traps.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8,
  parameter bit          EN_JAL      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic       bus_err
);

  localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state;
  state_e          state_nxt;
  op_class_t       cls;
  logic [TO_W-1:0] to_cnt;
  logic            pc_update;
  logic            branch;
  logic            ir_write;
  logic            mem_write;
  logic            reg_write;
  logic            mem_wait;
  logic            timeout_hit;

  op_class_decoder #(
    .EN_JAL(EN_JAL)
  ) u_dec (
    .op      (op),
    .op_class(cls),
    .imm_src (ImmSrc)
  );

  // States that sit waiting on the memory handshake.
  assign mem_wait    = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // Last allowed cycle without mem_ready: give up and trap.
  assign timeout_hit = TO_EN && mem_wait && !mem_ready && (to_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Memory-wait counter: restarts on every state change, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state_nxt != state) begin
      to_cnt <= '0;
    end else if (mem_wait && !mem_ready && (to_cnt != '1)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Sticky trap causes; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if ((state == S_DECODE) && cls.is_illegal) illegal <= 1'b1;
      if (timeout_hit)                           bus_err <= 1'b1;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_nxt = state;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_REGB;
    ALUOp     = ALUOP_ADD;
    unique case (state)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = mem_ready;
        pc_update = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target while the class is resolved.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (cls.is_load || cls.is_store) state_nxt = S_MEMADR;
        else if (cls.is_r)               state_nxt = S_EXECR;
        else if (cls.is_i)               state_nxt = S_EXECI;
        else if (cls.is_beq)             state_nxt = S_BEQ;
        else if (cls.is_jal)             state_nxt = S_JAL;
        else                             state_nxt = S_TRAP;
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_REGA;
        ALUSrcB   = SRCB_IMM;
        state_nxt = cls.is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_REGA;
        ALUSrcB   = SRCB_REGB;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_REGA;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_REGA;
        ALUSrcB   = SRCB_REGB;
        ALUOp     = ALUOP_SUB;
        branch    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        // PC <- target computed in DECODE; ALU forms OldPC+4 for rd.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
    if (timeout_hit) state_nxt = S_TRAP;
  end

  // Strobes are held off for as long as reset is asserted.
  assign PCWrite  = rst_n & (pc_update | (branch & zero));
  assign IRWrite  = rst_n & ir_write;
  assign MemWrite = rst_n & mem_write;
  assign RegWrite = rst_n & reg_write;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. Expected behaviour is built
// per instruction as a list of cycles from the instruction class, the
// memory wait counts and the timeout limit, then replayed against the DUT.
module tb_multicycle_control_fsm;

  localparam int TO = 4;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, bus_err;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  logic       pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b, berr_b;
  logic [1:0] rs_b, a_b, b_b, aop_b, imm_b;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .TO_W(8), .EN_JAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .bus_err(bus_err)
  );

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .TO_W(8), .EN_JAL(1'b0)) dut_nojal (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b),
    .RegWrite(rw_b), .ResultSrc(rs_b), .ALUSrcA(a_b), .ALUSrcB(b_b),
    .ALUOp(aop_b), .ImmSrc(imm_b), .illegal(ill_b), .bus_err(berr_b)
  );

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, a, b, aop;
    logic       ill, berr;
  } out_t;

  typedef struct packed {
    logic mr;
    out_t o;
  } step_t;

  typedef enum {C_LW, C_SW, C_R, C_I, C_BEQ, C_JAL, C_BAD} cls_e;

  step_t q[$];
  logic  m_ill = 1'b0;
  logic  m_berr = 1'b0;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic out_t observe();
    out_t r;
    r = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
         ALUOp, illegal, bus_err};
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic cls_e classify(input logic [6:0] o);
    case (o)
      LW:      return C_LW;
      SW:      return C_SW;
      RT:      return C_R;
      IT:      return C_I;
      BEQ:     return C_BEQ;
      JAL:     return C_JAL;
      default: return C_BAD;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    case (o)
      SW:      return 2'b01;
      BEQ:     return 2'b10;
      JAL:     return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Append one expected cycle; sticky flags come from the model state.
  function automatic void add(input logic mr, input logic pcw, input logic adr,
                              input logic mw, input logic irw, input logic rw,
                              input logic [1:0] rs, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] aop);
    step_t s;
    s.mr = mr;
    s.o  = {pcw, adr, mw, irw, rw, rs, a, b, aop, m_ill, m_berr};
    q.push_back(s);
  endfunction

  // Memory handshake of w stalled cycles; returns 1 if it times out.
  function automatic bit mem_phase(input int w, input bit is_fetch, input bit is_store);
    int n;
    n = (w < TO) ? w : TO;
    for (int i = 0; i < n; i++) begin
      if (is_fetch) add(1'b0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00);
      else          add(1'b0, 0, 1, is_store, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    if (w >= TO) begin
      m_berr = 1'b1;
      return 1'b1;
    end
    if (is_fetch) add(1'b1, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00);
    else          add(1'b1, 0, 1, is_store, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    return 1'b0;
  endfunction

  // Build the expected cycle list for one instruction, then replay it.
  task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input logic z,
                           input int trap_len, input int stop, input string tag,
                           output bit trapped);
    cls_e c;
    c = classify(o);
    q.delete();
    trapped = mem_phase(fw, 1'b1, 1'b0);
    if (!trapped) begin
      add(rb(), 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
      case (c)
        C_LW: begin
          add(rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
          trapped = mem_phase(mw, 1'b0, 1'b0);
          if (!trapped) add(rb(), 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00);
        end
        C_SW: begin
          add(rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
          trapped = mem_phase(mw, 1'b0, 1'b1);
        end
        C_R: begin
          add(rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
          add(rb(), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        C_I: begin
          add(rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
          add(rb(), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        C_BEQ: add(rb(), z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
        C_JAL: begin
          add(rb(), 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
          add(rb(), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        default: begin
          m_ill   = 1'b1;
          trapped = 1'b1;
        end
      endcase
    end
    if (trapped)
      for (int i = 0; i < trap_len; i++) add(rb(), 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < q.size(); i++) begin
      if (stop >= 0 && i >= stop) break;
      @(negedge clk);
      op        = o;
      zero      = z;
      mem_ready = q[i].mr;
      #1;
      check($sformatf("%s cyc%0d", tag, i), 16'(observe()), 16'(q[i].o));
      check($sformatf("%s imm%0d", tag, i), 16'(ImmSrc), 16'(exp_imm(o)));
    end
  endtask

  // Hold reset across an active edge, then release just after a posedge so
  // the next replay starts with a fresh FETCH.
  task automatic do_reset(input string tag);
    out_t idle;
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b1;
    #1;
    check({tag, " strobes_in_rst"}, 16'({PCWrite, MemWrite, IRWrite, RegWrite, illegal, bus_err}), 16'(0));
    check({tag, " nojal_in_rst"}, 16'({pcw_b, mw_b, irw_b, rw_b, ill_b, berr_b}), 16'(0));
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    m_ill     = 1'b0;
    m_berr    = 1'b0;
    #1;
    idle = {5'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    check({tag, " fetch_after_rst"}, 16'(observe()), 16'(idle));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit t;
    logic [6:0] o;
    int k;

    do_reset("reset");

    run_instr(LW, 0, 2, 1'b0, 0, -1, "lw_wait2", t);
    run_instr(SW, 1, 3, 1'b1, 0, -1, "sw_wait3", t);
    run_instr(BEQ, 0, 0, 1'b1, 0, -1, "beq_taken", t);
    run_instr(BEQ, 0, 0, 1'b0, 0, -1, "beq_not", t);
    run_instr(RT, 2, 0, 1'b0, 0, -1, "rtype", t);
    run_instr(IT, 0, 0, 1'b1, 0, -1, "itype", t);
    run_instr(JAL, 1, 0, 1'b0, 0, -1, "jal", t);

    run_instr(7'b1111111, 0, 0, 1'b1, 20, -1, "illegal_op", t);
    do_reset("after_illegal");

    // jal on both instances: the jal-disabled one must trap as illegal.
    run_instr(JAL, 0, 0, 1'b0, 0, -1, "jal_vs_nojal", t);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = rb();
      zero      = rb();
      #1;
      check($sformatf("nojal_trap cyc%0d", i),
            16'({pcw_b, mw_b, irw_b, rw_b, adr_b, ill_b, berr_b}), 16'(7'b0000010));
    end
    do_reset("after_nojal");

    // Reset in the middle of a stalled store.
    run_instr(SW, 0, 3, 1'b0, 0, 5, "sw_midrst", t);
    #2;
    rst_n = 1'b0;
    #1;
    check("memwrite_drop", 16'({PCWrite, MemWrite, IRWrite, RegWrite}), 16'(0));
    do_reset("after_midrst");

    run_instr(RT, 4, 0, 1'b0, 5, -1, "fetch_timeout", t);
    do_reset("after_fetch_to");
    run_instr(RT, 3, 0, 1'b0, 0, -1, "fetch_last_ok", t);
    run_instr(LW, 0, 3, 1'b0, 0, -1, "memread_last_ok", t);
    run_instr(LW, 0, 4, 1'b0, 5, -1, "memread_timeout", t);
    do_reset("after_mem_to");

    // Randomized instruction stream.
    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(7, 0);
      case (k)
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = BEQ;
        5: o = JAL;
        6: begin
          o = 7'($urandom);
          while (classify(o) != C_BAD) o = 7'($urandom);
        end
        default: o = (rb() ? LW : SW);
      endcase
      run_instr(o, ($urandom_range(15, 0) == 0) ? TO : $urandom_range(3, 0),
                (k == 7) ? TO : $urandom_range(3, 0), rb(), 3, -1,
                $sformatf("rnd%0d", n), t);
      if (t) do_reset($sformatf("rnd%0d_rst", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
